// File: rtl/mac_acc.sv
// Pipelined multiply-accumulate with framed accumulation (first/last), per-term
// signed/unsigned products, sticky overflow and optional output saturation.
module mac_acc #(
    parameter int A_W        = 16,
    parameter int B_W        = 16,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 32,
    parameter int MUL_STAGES = 2,
    parameter int SAT        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             signed_mode,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_overflow,
    output logic [15:0]      term_count
);

    localparam int P_W = A_W + B_W;

    logic           v_in_reg, f_in_reg, l_in_reg, s_in_reg;
    logic [A_W-1:0] a_reg;
    logic [B_W-1:0] b_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_in_reg <= 1'b0;
            f_in_reg <= 1'b0;
            l_in_reg <= 1'b0;
            s_in_reg <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
        end else begin
            v_in_reg <= in_valid;
            f_in_reg <= in_first;
            l_in_reg <= in_last;
            s_in_reg <= signed_mode;
            a_reg    <= a;
            b_reg    <= b;
        end
    end

    // One extra bit per operand lets a single signed multiplier cover both modes.
    logic signed [A_W:0]   a_ext;
    logic signed [B_W:0]   b_ext;
    logic signed [P_W+1:0] prod_full;
    logic [P_W-1:0]        prod_next;

    always_comb begin
        a_ext     = {s_in_reg & a_reg[A_W-1], a_reg};
        b_ext     = {s_in_reg & b_reg[B_W-1], b_reg};
        prod_full = (P_W+2)'(a_ext) * (P_W+2)'(b_ext);
        prod_next = prod_full[P_W-1:0];
    end

    for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_mul
        logic [P_W-1:0] prod_reg;
        logic           v_reg, f_reg, l_reg, s_reg;
        logic [P_W-1:0] prod_prev;
        logic           v_prev, f_prev, l_prev, s_prev;

        if (gi == 0) begin : g_src
            assign prod_prev = prod_next;
            assign v_prev    = v_in_reg;
            assign f_prev    = f_in_reg;
            assign l_prev    = l_in_reg;
            assign s_prev    = s_in_reg;
        end else begin : g_src
            assign prod_prev = g_mul[gi-1].prod_reg;
            assign v_prev    = g_mul[gi-1].v_reg;
            assign f_prev    = g_mul[gi-1].f_reg;
            assign l_prev    = g_mul[gi-1].l_reg;
            assign s_prev    = g_mul[gi-1].s_reg;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prod_reg <= '0;
                v_reg    <= 1'b0;
                f_reg    <= 1'b0;
                l_reg    <= 1'b0;
                s_reg    <= 1'b0;
            end else begin
                prod_reg <= prod_prev;
                v_reg    <= v_prev;
                f_reg    <= f_prev;
                l_reg    <= l_prev;
                s_reg    <= s_prev;
            end
        end
    end

    logic [P_W-1:0] prod_t;
    logic           v_t, f_t, l_t, s_t;

    assign prod_t = g_mul[MUL_STAGES-1].prod_reg;
    assign v_t    = g_mul[MUL_STAGES-1].v_reg;
    assign f_t    = g_mul[MUL_STAGES-1].f_reg;
    assign l_t    = g_mul[MUL_STAGES-1].l_reg;
    assign s_t    = g_mul[MUL_STAGES-1].s_reg;

    logic [ACC_W-1:0] acc_reg, acc_next, ext, base;
    logic [ACC_W:0]   sum;
    logic             sticky_reg, sticky_next, wrap;
    logic [15:0]      count_reg, count_next;
    logic             res_valid_reg, res_signed_reg;

    always_comb begin
        if (s_t) ext = ACC_W'($signed(prod_t));
        else     ext = ACC_W'(prod_t);
        base = f_t ? '0 : acc_reg;
        sum  = {1'b0, base} + {1'b0, ext};
        // Signed wrap: equal operand signs but a different result sign.
        if (s_t) wrap = (base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
        else     wrap = sum[ACC_W];
        acc_next    = sum[ACC_W-1:0];
        sticky_next = (~f_t & sticky_reg) | wrap;
        if (f_t)             count_next = 16'd1;
        else if (&count_reg) count_next = count_reg;
        else                 count_next = count_reg + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg        <= '0;
            sticky_reg     <= 1'b0;
            count_reg      <= '0;
            res_valid_reg  <= 1'b0;
            res_signed_reg <= 1'b0;
        end else begin
            res_valid_reg  <= v_t & l_t;
            res_signed_reg <= s_t;
            if (v_t) begin
                acc_reg    <= acc_next;
                sticky_reg <= sticky_next;
                count_reg  <= count_next;
            end
        end
    end

    logic             fits_signed, fits_unsigned, fits;
    logic [OUT_W-1:0] sat_val, data_next;

    always_comb begin
        fits_signed   = (&acc_reg[ACC_W-1:OUT_W-1]) | ~(|acc_reg[ACC_W-1:OUT_W-1]);
        fits_unsigned = ((acc_reg >> OUT_W) == '0);
        fits          = res_signed_reg ? fits_signed : fits_unsigned;
        if (!res_signed_reg)     sat_val = '1;
        else if (acc_reg[ACC_W-1]) sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        else                     sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        data_next = ((SAT != 0) && !fits) ? sat_val : acc_reg[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
            term_count   <= '0;
        end else begin
            out_valid <= res_valid_reg;
            if (res_valid_reg) begin
                out_data     <= data_next;
                out_overflow <= sticky_reg | ~fits;
                term_count   <= count_reg;
            end
        end
    end

endmodule

// File: tb/tb_mac_acc.sv
// Scoreboard bench for mac_acc: a saturating and a truncating instance share
// stimulus; expected results are queued at drive time and checked at output.
module tb_mac_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_first, in_last, signed_mode;
    logic [15:0] a, b;

    logic        ov_s, of_s, ov_t, of_t;
    logic [31:0] d_s, d_t;
    logic [15:0] tc_s, tc_t;

    always #5 clk = ~clk;

    mac_acc #(.SAT(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .signed_mode(signed_mode), .a(a), .b(b),
        .out_valid(ov_s), .out_data(d_s), .out_overflow(of_s), .term_count(tc_s)
    );

    mac_acc #(.SAT(0)) u_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .signed_mode(signed_mode), .a(a), .b(b),
        .out_valid(ov_t), .out_data(d_t), .out_overflow(of_t), .term_count(tc_t)
    );

    typedef struct {
        int          cyc;
        logic [31:0] d_sat;
        logic [31:0] d_trunc;
        logic        ovf;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic [39:0] m_acc = '0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_cnt = '0;

    localparam longint S40_MAX = (longint'(1) << 39) - 1;
    localparam longint S40_MIN = -(longint'(1) << 39);
    localparam longint U40_MAX = (longint'(1) << 40) - 1;
    localparam longint S32_MAX = (longint'(1) << 31) - 1;
    localparam longint S32_MIN = -(longint'(1) << 31);
    localparam longint U32_MAX = (longint'(1) << 32) - 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference behaviour in integer arithmetic: wraps judged by the exact sum.
    task automatic model_term(input logic f, input logic l, input logic sm,
                              input logic [15:0] ta, input logic [15:0] tb);
        longint      p, sum, v;
        logic [39:0] base;
        logic        wrap, fits;
        exp_t        x;
        if (sm) p = longint'($signed(ta)) * longint'($signed(tb));
        else    p = longint'(ta) * longint'(tb);
        base = f ? 40'd0 : m_acc;
        if (sm) begin
            sum  = longint'($signed(base)) + p;
            wrap = (sum > S40_MAX) || (sum < S40_MIN);
        end else begin
            sum  = longint'(base) + p;
            wrap = (sum > U40_MAX);
        end
        m_acc = sum[39:0];
        m_ovf = (f ? 1'b0 : m_ovf) | wrap;
        if (f) m_cnt = 16'd1;
        else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (l) begin
            x.d_trunc = m_acc[31:0];
            if (sm) begin
                v    = longint'($signed(m_acc));
                fits = (v >= S32_MIN) && (v <= S32_MAX);
                x.d_sat = fits ? m_acc[31:0] : (v < 0 ? 32'h8000_0000 : 32'h7FFF_FFFF);
            end else begin
                v    = longint'(m_acc);
                fits = (v <= U32_MAX);
                x.d_sat = fits ? m_acc[31:0] : 32'hFFFF_FFFF;
            end
            x.ovf = m_ovf | ~fits;
            x.cnt = m_cnt;
            x.cyc = cyc + 5;
            q.push_back(x);
            $display("drive last: sm=%0d a=0x%0h b=0x%0h -> exp sat=0x%0h trunc=0x%0h ovf=%0d cnt=%0d",
                     sm, ta, tb, x.d_sat, x.d_trunc, x.ovf, x.cnt);
        end
    endtask

    task automatic drive(input logic f, input logic l, input logic sm,
                         input logic [15:0] ta, input logic [15:0] tb);
        in_valid = 1'b1; in_first = f; in_last = l; signed_mode = sm; a = ta; b = tb;
        model_term(f, l, sm, ta, tb);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            $display("result: sat=0x%0h trunc=0x%0h ovf=%0d/%0d cnt=%0d", d_s, d_t, of_s, of_t, tc_s);
            check("valid_sat", 64'(ov_s), 64'(1'b1));
            check("valid_trunc", 64'(ov_t), 64'(1'b1));
            check("data_sat", 64'(d_s), 64'(e.d_sat));
            check("data_trunc", 64'(d_t), 64'(e.d_trunc));
            check("ovf_sat", 64'(of_s), 64'(e.ovf));
            check("ovf_trunc", 64'(of_t), 64'(e.ovf));
            check("count_sat", 64'(tc_s), 64'(e.cnt));
            check("count_trunc", 64'(tc_t), 64'(e.cnt));
        end else if (ov_s || ov_t) begin
            check("spurious_valid", 64'({ov_s, ov_t}), 64'd0);
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'({ov_s, ov_t}), 64'd0);
        check({tag, "_data"}, 64'({d_s, d_t}), 64'd0);
        check({tag, "_ovf"}, 64'({of_s, of_t}), 64'd0);
        check({tag, "_count"}, 64'({tc_s, tc_t}), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        signed_mode = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Unsigned single term
        drive(1, 1, 0, 16'd3, 16'd5);
        idle(6);

        // Signed four terms back-to-back: -6 + 20 + 7 - 100 = -79
        drive(1, 0, 1, -16'sd2, 16'sd3);
        drive(0, 0, 1, 16'sd4, 16'sd5);
        drive(0, 0, 1, -16'sd7, -16'sd1);
        drive(0, 1, 1, 16'sd100, -16'sd1);
        idle(6);

        // Unsigned saturation / truncation
        drive(1, 0, 0, 16'hFFFF, 16'hFFFF);
        drive(0, 1, 0, 16'hFFFF, 16'hFFFF);
        idle(6);

        // Same signed stream with bubbles
        drive(1, 0, 1, -16'sd2, 16'sd3);
        idle(1);
        drive(0, 0, 1, 16'sd4, 16'sd5);
        idle(3);
        drive(0, 0, 1, -16'sd7, -16'sd1);
        idle(2);
        drive(0, 1, 1, 16'sd100, -16'sd1);
        idle(6);

        // Back-to-back frames
        drive(1, 1, 0, 16'd2, 16'd2);
        drive(1, 1, 0, 16'd3, 16'd3);
        idle(6);

        // Mixed modes: signed -1 then unsigned +1 carries out of the accumulator
        drive(1, 0, 1, -16'sd1, 16'sd1);
        drive(0, 1, 0, 16'd1, 16'd1);
        idle(6);

        // Signed accumulator wrap over many large products
        drive(1, 0, 1, 16'h8000, 16'h8000);
        for (int i = 0; i < 598; i++) drive(0, 0, 1, 16'h8000, 16'h8000);
        drive(0, 1, 1, 16'h8000, 16'h8000);
        idle(6);

        // Reset two edges after a last term is captured
        drive(1, 1, 0, 16'd9, 16'd9);
        idle(2);
        rst = 1'b1;
        q.delete();
        m_acc = '0; m_ovf = 1'b0; m_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrst");
        idle(6);
        drive(1, 1, 0, 16'd6, 16'd7);
        idle(2);

        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
